// File: rtl/axi_stream_demux_1to2.sv
// rtl/axi_stream_demux_1to2.sv - packet-atomic 1-to-2 AXI-Stream demultiplexer with per-output 2-entry buffers
//
// axi_stream_demux_1to2
//   Steers one upstream stream to output 0 or output 1. The destination is
//   taken from sel on the first beat of a packet and held until the tlast beat.
//   Each output owns a 2-entry registered buffer, so tready_in never depends
//   combinationally on tready_0/tready_1.
//   Ports:
//     clk, rst                        clock, synchronous active-high reset
//     sel                             destination select, sampled at packet start
//     tdata_in/tvalid_in/tlast_in     upstream stream, tready_in back to it
//     tdata_x/tvalid_x/tlast_x        output x stream, tready_x from downstream
//     cnt_x                           beats delivered on output x (wrapping)
//
// axi_stream_demux_1to2_buf
//   2-entry FIFO for one output plus its delivered-beat counter.
//   Ports:
//     clk, rst                        clock, synchronous active-high reset
//     push, push_data, push_last      write side (never pushed while full)
//     tdata/tvalid/tlast/tready       read side, head entry drives the stream
//     full                            registered full flag
//     cnt                             beats popped (tvalid & tready), wrapping

module axi_stream_demux_1to2_buf #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              push_last,
    output logic [DATA_W-1:0] tdata,
    output logic              tvalid,
    output logic              tlast,
    input  logic              tready,
    output logic              full,
    output logic [CNT_W-1:0]  cnt
);

    logic [DATA_W-1:0] mem_data [2];
    logic [1:0]        mem_last;
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        count;
    logic              pop;

    assign tvalid = (count != 2'd0);
    assign full   = (count == 2'd2);
    assign tdata  = mem_data[rd_ptr];
    assign tlast  = mem_last[rd_ptr];
    assign pop    = tvalid & tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Storage is cleared so the head presents zero data after reset.
            mem_data[0] <= '0;
            mem_data[1] <= '0;
            mem_last    <= '0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            count       <= 2'd0;
            cnt         <= '0;
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= push_data;
                mem_last[wr_ptr] <= push_last;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
                cnt    <= cnt + CNT_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

module axi_stream_demux_1to2 #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic [DATA_W-1:0] tdata_in,
    input  logic              tvalid_in,
    input  logic              tlast_in,
    output logic              tready_in,
    output logic [DATA_W-1:0] tdata_0,
    output logic              tvalid_0,
    output logic              tlast_0,
    input  logic              tready_0,
    output logic [DATA_W-1:0] tdata_1,
    output logic              tvalid_1,
    output logic              tlast_1,
    input  logic              tready_1,
    output logic [CNT_W-1:0]  cnt_0,
    output logic [CNT_W-1:0]  cnt_1
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0] state;
    logic       lock_sel;
    logic       dest;
    logic       accept;
    logic       full_0;
    logic       full_1;

    // In IDLE sel is used directly so a change takes effect the same cycle.
    assign dest      = (state == LOCKED) ? lock_sel : sel;
    assign tready_in = !rst && !(dest ? full_1 : full_0);
    assign accept    = tvalid_in & tready_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            lock_sel <= 1'b0;
        end else if (accept) begin
            case (state)
                IDLE: begin
                    // Single-beat packets never lock.
                    if (!tlast_in) begin
                        state    <= LOCKED;
                        lock_sel <= sel;
                    end
                end
                default: begin
                    if (tlast_in) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    axi_stream_demux_1to2_buf #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_buf_0 (
        .clk       (clk),
        .rst       (rst),
        .push      (accept & !dest),
        .push_data (tdata_in),
        .push_last (tlast_in),
        .tdata     (tdata_0),
        .tvalid    (tvalid_0),
        .tlast     (tlast_0),
        .tready    (tready_0),
        .full      (full_0),
        .cnt       (cnt_0)
    );

    axi_stream_demux_1to2_buf #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_buf_1 (
        .clk       (clk),
        .rst       (rst),
        .push      (accept & dest),
        .push_data (tdata_in),
        .push_last (tlast_in),
        .tdata     (tdata_1),
        .tvalid    (tvalid_1),
        .tlast     (tlast_1),
        .tready    (tready_1),
        .full      (full_1),
        .cnt       (cnt_1)
    );

endmodule

// File: tb/tb_axi_stream_demux_1to2.sv
// tb/tb_axi_stream_demux_1to2.sv - self-checking bench for axi_stream_demux_1to2

module tb_axi_stream_demux_1to2;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sel = 1'b0;
    logic [DATA_W-1:0] tdata_in = '0;
    logic              tvalid_in = 1'b0;
    logic              tlast_in = 1'b0;
    logic              tready_in;
    logic [DATA_W-1:0] tdata_0;
    logic              tvalid_0;
    logic              tlast_0;
    logic              tready_0 = 1'b0;
    logic [DATA_W-1:0] tdata_1;
    logic              tvalid_1;
    logic              tlast_1;
    logic              tready_1 = 1'b0;
    logic [CNT_W-1:0]  cnt_0;
    logic [CNT_W-1:0]  cnt_1;

    int checks = 0;
    int errors = 0;

    axi_stream_demux_1to2 #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sel       (sel),
        .tdata_in  (tdata_in),
        .tvalid_in (tvalid_in),
        .tlast_in  (tlast_in),
        .tready_in (tready_in),
        .tdata_0   (tdata_0),
        .tvalid_0  (tvalid_0),
        .tlast_0   (tlast_0),
        .tready_0  (tready_0),
        .tdata_1   (tdata_1),
        .tvalid_1  (tvalid_1),
        .tlast_1   (tlast_1),
        .tready_1  (tready_1),
        .cnt_0     (cnt_0),
        .cnt_1     (cnt_1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per-output queues of {last, data}, packet lock flag,
    // and delivered-beat counts. Updated at negedge from the inputs that
    // will be seen at the next rising edge.
    logic [DATA_W:0] q0 [$];
    logic [DATA_W:0] q1 [$];
    bit              m_ok = 1'b0;
    bit              m_locked = 1'b0;
    bit              m_lock_sel = 1'b0;
    int              m_cnt0 = 0;
    int              m_cnt1 = 0;

    always @(negedge clk) begin
        bit m_dest;
        bit exp_ready;
        bit do_pop0;
        bit do_pop1;
        bit acc;
        m_dest    = m_locked ? m_lock_sel : sel;
        exp_ready = !rst && ((m_dest ? q1.size() : q0.size()) < 2);
        if (m_ok) begin
            chk("tvalid_0", tvalid_0, q0.size() != 0);
            chk("tvalid_1", tvalid_1, q1.size() != 0);
            if (q0.size() != 0) chk("head_0", {tlast_0, tdata_0}, q0[0]);
            if (q1.size() != 0) chk("head_1", {tlast_1, tdata_1}, q1[0]);
            chk("cnt_0", cnt_0, m_cnt0);
            chk("cnt_1", cnt_1, m_cnt1);
            chk("tready_in", tready_in, exp_ready);
        end
        if (rst) begin
            q0.delete();
            q1.delete();
            m_locked = 1'b0;
            m_cnt0   = 0;
            m_cnt1   = 0;
            m_ok     = 1'b1;
        end else if (m_ok) begin
            do_pop0 = (q0.size() != 0) && tready_0;
            do_pop1 = (q1.size() != 0) && tready_1;
            acc     = tvalid_in && exp_ready;
            if (do_pop0) begin
                void'(q0.pop_front());
                m_cnt0 = (m_cnt0 + 1) % (1 << CNT_W);
            end
            if (do_pop1) begin
                void'(q1.pop_front());
                m_cnt1 = (m_cnt1 + 1) % (1 << CNT_W);
            end
            if (acc) begin
                if (m_dest) q1.push_back({tlast_in, tdata_in});
                else        q0.push_back({tlast_in, tdata_in});
                if (!m_locked && !tlast_in) begin
                    m_locked   = 1'b1;
                    m_lock_sel = sel;
                end else if (m_locked && tlast_in) begin
                    m_locked = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [DATA_W-1:0] lock_beats [3];

    initial begin
        lock_beats[0] = 32'h78;
        lock_beats[1] = 32'h85;
        lock_beats[2] = 32'h46;

        // Reset / idle
        step();
        chk("rst_tready_in", tready_in, 0);
        chk("rst_tvalid_0", tvalid_0, 0);
        chk("rst_tvalid_1", tvalid_1, 0);
        chk("rst_cnt_0", cnt_0, 0);
        chk("rst_cnt_1", cnt_1, 0);
        step();
        rst = 1'b0;
        #1;
        chk("release_tready_in", tready_in, 1);

        // Single-beat routing
        tready_0 = 1'b1; tready_1 = 1'b1;
        sel = 1'b0; tdata_in = 32'h45; tlast_in = 1'b1; tvalid_in = 1'b1;
        step();
        tvalid_in = 1'b0;
        chk("sb0_tvalid_0", tvalid_0, 1);
        chk("sb0_tdata_0", tdata_0, 32'h45);
        chk("sb0_tvalid_1", tvalid_1, 0);
        step();
        chk("sb0_cnt_0", cnt_0, 1);
        sel = 1'b1; tdata_in = 32'h96; tvalid_in = 1'b1;
        step();
        tvalid_in = 1'b0;
        chk("sb1_tvalid_1", tvalid_1, 1);
        chk("sb1_tdata_1", tdata_1, 32'h96);
        chk("sb1_tvalid_0", tvalid_0, 0);
        step();
        chk("sb1_cnt_1", cnt_1, 1);

        // Packet lock with sel toggling every beat
        for (int i = 0; i < 3; i++) begin
            sel = (i % 2 == 0);
            tdata_in = lock_beats[i];
            tlast_in = (i == 2);
            tvalid_in = 1'b1;
            step();
            chk("lock_tvalid_1", tvalid_1, 1);
            chk("lock_tdata_1", tdata_1, lock_beats[i]);
            chk("lock_tvalid_0", tvalid_0, 0);
        end
        tvalid_in = 1'b0;
        step();
        chk("lock_cnt_1", cnt_1, 4);
        sel = 1'b0; tdata_in = 32'h11; tlast_in = 1'b1; tvalid_in = 1'b1;
        step();
        tvalid_in = 1'b0;
        chk("after_lock_tvalid_0", tvalid_0, 1);
        chk("after_lock_tdata_0", tdata_0, 32'h11);
        step();
        chk("after_lock_cnt_0", cnt_0, 2);

        // Backpressure on output 0
        tready_0 = 1'b0; sel = 1'b0;
        tdata_in = 32'h124; tlast_in = 1'b0; tvalid_in = 1'b1;
        step();
        tdata_in = 32'h125;
        step();
        chk("bp_tready_in_full", tready_in, 0);
        tdata_in = 32'h155; tlast_in = 1'b1;
        step();
        chk("bp_tready_in_held", tready_in, 0);
        chk("bp_head_held", tdata_0, 32'h124);
        tready_0 = 1'b1;
        step();
        chk("bp_drain_1", tdata_0, 32'h125);
        chk("bp_tready_in_free", tready_in, 1);
        step();
        chk("bp_drain_2", tdata_0, 32'h155);
        chk("bp_drain_2_valid", tvalid_0, 1);
        tvalid_in = 1'b0; tlast_in = 1'b0;
        step();
        chk("bp_empty", tvalid_0, 0);
        chk("bp_cnt_0", cnt_0, 5);

        // Isolation: output 0 full and stalled, packet to output 1 flows
        tready_0 = 1'b0; sel = 1'b0; tlast_in = 1'b1; tvalid_in = 1'b1;
        tdata_in = 32'hA0;
        step();
        tdata_in = 32'hA1;
        step();
        sel = 1'b1; tdata_in = 32'h136;
        #1;
        chk("iso_tready_in", tready_in, 1);
        step();
        tvalid_in = 1'b0;
        chk("iso_tvalid_1", tvalid_1, 1);
        chk("iso_tdata_1", tdata_1, 32'h136);
        chk("iso_tvalid_0", tvalid_0, 1);
        chk("iso_tdata_0", tdata_0, 32'hA0);
        step();
        chk("iso_cnt_1", cnt_1, 5);
        chk("iso_tdata_0_stable", tdata_0, 32'hA0);
        tready_0 = 1'b1;
        step();
        step();
        chk("iso_cnt_0", cnt_0, 7);

        // Reset mid-packet
        tready_0 = 1'b0; sel = 1'b0; tdata_in = 32'h50; tlast_in = 1'b0; tvalid_in = 1'b1;
        step();
        tvalid_in = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_tvalid_0", tvalid_0, 0);
        chk("mid_rst_cnt_0", cnt_0, 0);
        sel = 1'b1; tdata_in = 32'h77; tlast_in = 1'b1; tvalid_in = 1'b1; tready_1 = 1'b1;
        step();
        tvalid_in = 1'b0;
        chk("mid_rst_route_valid", tvalid_1, 1);
        chk("mid_rst_route_data", tdata_1, 32'h77);
        chk("mid_rst_route_other", tvalid_0, 0);
        step();
        chk("mid_rst_cnt_1", cnt_1, 1);

        // Counter wrap: 17 beats on output 0 with a 4-bit counter
        tready_0 = 1'b1; sel = 1'b0; tlast_in = 1'b1; tvalid_in = 1'b1;
        for (int i = 0; i < 17; i++) begin
            tdata_in = 32'h200 + i;
            step();
        end
        tvalid_in = 1'b0;
        step();
        chk("wrap_cnt_0", cnt_0, 1);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            sel       = $urandom_range(0, 1);
            tvalid_in = ($urandom_range(0, 9) < 7);
            tlast_in  = ($urandom_range(0, 9) < 3);
            tdata_in  = $urandom;
            tready_0  = ($urandom_range(0, 9) < 6);
            tready_1  = ($urandom_range(0, 9) < 6);
            step();
        end
        rst = 1'b0; tvalid_in = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
